// File: rtl/seg7_digit_scroller_pkg.sv
// Purpose: shared types and segment tables for the 7-segment digit scroller family.
// Latency: none (types and constants only).
// Backpressure: none.
//
// Contents:
//   mode_t  : display mode as driven on the mode pins
//   state_t : display FSM state
//   SEG_HEX : gfedcba pattern per hex digit, 1 = segment lit
//   SEG_DP  : decimal-point bit within the SEG bus
package seg7_digit_scroller_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_SCROLL = 2'b01,
      MODE_BLINK  = 2'b10,
      MODE_OFF    = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_t;

   // Indexed by hex digit value; the leftmost entry is digit F.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   localparam logic [7:0] SEG_DP = 8'h80;

endpackage

// File: rtl/seg7_digit_scroller_if.sv
// Purpose: control and status bundle between the board control logic and the scroller.
// Latency: none (wires only).
// Backpressure: none; a write into a full buffer is silently dropped by the scroller.
//
// master : wr_en, wr_data, clr, mode, sel driven; SEG, idx, count, full, empty observed
// slave  : the scroller side of the same signals
interface seg7_digit_scroller_if #(
   parameter int NDIGITS    = 4,
   parameter int DIGIT_BITS = 4,
   parameter int NBITS_SEG  = 8
);
   import seg7_digit_scroller_pkg::*;

   localparam int IW = $clog2(NDIGITS);

   logic                  wr_en;
   logic [DIGIT_BITS-1:0] wr_data;
   logic                  clr;
   mode_t                 mode;
   logic [IW-1:0]         sel;

   logic [NBITS_SEG-1:0]  SEG;
   logic [IW-1:0]         idx;
   logic [IW:0]           count;
   logic                  full;
   logic                  empty;

   modport master (
      output wr_en, wr_data, clr, mode, sel,
      input  SEG, idx, count, full, empty
   );

   modport slave (
      input  wr_en, wr_data, clr, mode, sel,
      output SEG, idx, count, full, empty
   );

endinterface

// File: rtl/seg7_digit_scroller_hex_decoder.sv
// Purpose: combinational hex digit to gfedcba segment pattern, shared by the lab tops.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
//
// digit : hex value 0..F
// seg   : gfedcba pattern, 1 = lit
module seg7_hex_decoder (
   input  logic [3:0] digit,
   output logic [6:0] seg
);
   import seg7_digit_scroller_pkg::*;

   assign seg = SEG_HEX[digit];

endmodule

// File: rtl/seg7_digit_scroller.sv
// Purpose: hex digit buffer presented on a 7-segment bus in static, scroll or blink-scroll mode.
// Latency: SEG/idx registered, one edge after the state they reflect; a write shows on SEG two edges later at the earliest.
// Backpressure: none; writes while full (or together with clr) are dropped.
//
// clk_2, reset : clock and synchronous active-high reset
// bus.wr_en/wr_data : append one digit
// bus.clr           : empty the buffer
// bus.mode/sel      : display mode, static digit select
// bus.SEG/idx       : segment pattern (bit7 = dp) and index shown
// bus.count/full/empty : buffer fill status
module seg7_digit_scroller #(
   parameter int NDIGITS     = 4,
   parameter int DIGIT_BITS  = 4,
   parameter int HOLD_CYCLES = 2,
   parameter int NBITS_SEG   = 8
) (
   input logic                  clk_2,
   input logic                  reset,
   seg7_digit_scroller_if.slave bus
);
   import seg7_digit_scroller_pkg::*;

   localparam int IW = $clog2(NDIGITS);
   localparam int CW = IW + 1;
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   logic [DIGIT_BITS-1:0] buf_q [NDIGITS];
   logic [IW-1:0]         wr_ptr_q;
   logic [CW-1:0]         count_q;
   logic                  full;
   logic                  empty;
   logic                  wr_ok;

   state_t                state_q;
   state_t                state_d;
   logic [IW-1:0]         idx_q;
   logic [IW-1:0]         idx_d;
   logic [IW-1:0]         idx_adv;
   logic [IW-1:0]         disp_idx;
   logic [HW-1:0]         hold_q;
   logic [HW-1:0]         hold_d;
   mode_t                 mode_q;
   logic                  mode_chg;
   logic                  is_last;
   logic                  hold_done;
   logic                  sel_valid;

   logic [3:0]            dec_in;
   logic [6:0]            dec_seg;
   logic [NBITS_SEG-1:0]  seg_d;
   logic [NBITS_SEG-1:0]  seg_q;

   // ------------------------------------------------------------------
   // Digit buffer. Nothing is ever popped, so logical entry i sits at
   // physical slot i: clr rewinds wr_ptr to 0 and writes stop at full.
   // ------------------------------------------------------------------
   assign full  = (count_q == CW'(NDIGITS));
   assign empty = (count_q == '0);
   assign wr_ok = !reset && bus.wr_en && !full && !bus.clr;

   always_ff @(posedge clk_2) begin
      if (reset || bus.clr) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (wr_ok) begin
         wr_ptr_q <= wr_ptr_q + IW'(1);
         count_q  <= count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_2) begin
      if (wr_ok) begin
         buf_q[wr_ptr_q] <= bus.wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Shared decode terms
   // ------------------------------------------------------------------
   // mode_q holds last cycle's mode; any difference restarts the display.
   assign mode_chg  = (bus.mode != mode_q);
   // Never true while empty: count-1 then exceeds any idx value.
   assign is_last   = (CW'(idx_q) == count_q - CW'(1));
   assign idx_adv   = is_last ? '0 : idx_q + IW'(1);
   assign hold_done = (hold_q == HW'(HOLD_CYCLES - 1));
   assign sel_valid = (CW'(bus.sel) < count_q);
   // Static mode shows sel directly so SEG and idx move together.
   assign disp_idx  = (bus.mode == MODE_STATIC) ? bus.sel : idx_q;
   assign dec_in    = 4'(buf_q[disp_idx]);

   seg7_hex_decoder u_dec (
      .digit (dec_in),
      .seg   (dec_seg)
   );

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
         mode_q  <= MODE_OFF;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         mode_q  <= bus.mode;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state. Priority: clr, mode change, static, off/empty,
   // then the scroll/blink sequencing.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      if (bus.clr) begin
         state_d = IDLE;
         idx_d   = '0;
         hold_d  = '0;
      end else if (mode_chg) begin
         state_d = (!empty && bus.mode != MODE_OFF) ? SHOW : IDLE;
         idx_d   = '0;
         hold_d  = '0;
      end else if (bus.mode == MODE_STATIC) begin
         // hold counter deliberately left frozen
         state_d = empty ? IDLE : SHOW;
         idx_d   = bus.sel;
      end else if (empty || bus.mode == MODE_OFF) begin
         state_d = IDLE;
         idx_d   = '0;
         hold_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SHOW;
               idx_d   = '0;
               hold_d  = '0;
            end
            SHOW: begin
               if (hold_done) begin
                  hold_d = '0;
                  if (bus.mode == MODE_BLINK) begin
                     state_d = BLANK;
                  end else begin
                     idx_d = idx_adv;
                  end
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
            BLANK: begin
               if (hold_done) begin
                  hold_d  = '0;
                  state_d = SHOW;
                  idx_d   = idx_adv;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
               hold_d  = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM: output pattern. The cycle in which the mode changes is forced
   // blank so a stale idx from the old mode never reaches the pins.
   // ------------------------------------------------------------------
   always_comb begin
      seg_d = '0;
      if (!mode_chg && state_q == SHOW) begin
         case (bus.mode)
            MODE_STATIC: begin
               if (sel_valid) begin
                  seg_d[6:0] = dec_seg;
               end
            end
            MODE_SCROLL, MODE_BLINK: begin
               seg_d[6:0] = dec_seg;
               if (is_last) begin
                  seg_d = seg_d | NBITS_SEG'(SEG_DP);
               end
            end
            default: seg_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         seg_q <= '0;
      end else begin
         seg_q <= seg_d;
      end
   end

   assign bus.SEG   = seg_q;
   assign bus.idx   = idx_q;
   assign bus.count = count_q;
   assign bus.full  = full;
   assign bus.empty = empty;

endmodule
